// File: rtl/rr_arbiter_8.sv
// ============================================================================
//  Module   : rr_arbiter_8
//  Purpose  : 8-way round-robin arbiter with bounded hold and a break-before-
//             make gap cycle; drives a 3x8 decoder (A,B,C,En) plus a one-hot grant.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       sel_en,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam bit               C_LIMITED   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              sel_en_q, sel_en_d;
  logic [7:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic [2:0]        winner;
  logic [2:0]        cand;

  // Scan from the highest offset down so the closest requester to ptr wins.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = '0;
    idx_d      = idx_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          idx_d   = winner;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A release in the same cycle as the limit takes precedence.
        if (!req[idx_q]) begin
          state_d = ST_GAP;
          ptr_d   = idx_q + 3'd1;
        end else if (C_LIMITED && (hold_cnt_q == C_HOLD_LAST)) begin
          state_d   = ST_GAP;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sel_en_d = (state_d == ST_GRANT);
    busy_d   = (state_d != ST_IDLE);
    grant_d  = sel_en_d ? (8'b1 << idx_d) : 8'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      sel_en_q   <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      idx_q      <= idx_d;
      sel_en_q   <= sel_en_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign sel_a   = idx_q[2];
  assign sel_b   = idx_q[1];
  assign sel_c   = idx_q[0];
  assign sel_en  = sel_en_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
// ============================================================================
//  Module   : tb_rr_arbiter_8
//  Purpose  : Scoreboard bench for rr_arbiter_8: expected ownerships are queued
//             by the stimulus and matched by a monitor as each ownership ends.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       sel_a, sel_b, sel_c, sel_en, busy, timeout;
  logic [7:0] grant;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] idx;
    int         len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel_c   (sel_c),
    .sel_en  (sel_en),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] idx, input int len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus ownership tracking against the queue.
  logic       prev_en = 1'b0;
  logic [2:0] cur_idx = '0;
  int         cur_len = 0;

  always @(negedge clk) begin
    logic [2:0] idx;
    exp_t       e;
    idx = {sel_a, sel_b, sel_c};
    check("grant_decode", {24'h0, grant}, {24'h0, (sel_en ? (8'b1 << idx) : 8'h00)});
    check("grant_onehot", {31'h0, ($countones(grant) <= 1)}, 32'd1);
    if (timeout && !(prev_en && !sel_en)) begin
      check("timeout_stray", {31'h0, timeout}, 32'd0);
    end
    if (sel_en && !prev_en) begin
      cur_idx = idx;
      cur_len = 1;
    end else if (sel_en && prev_en) begin
      check("owner_back_to_back", {29'h0, idx}, {29'h0, cur_idx});
      cur_len++;
    end else if (!sel_en && prev_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ownership", {29'h0, cur_idx}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("owner_idx", {29'h0, cur_idx}, {29'h0, e.idx});
        check("owner_len", cur_len, e.len);
        check("owner_timeout", {31'h0, timeout}, {31'h0, e.to});
      end
    end
    prev_en = sel_en;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Idle after reset: nothing asserted for 10 cycles.
    do_reset();
    check("reset_outputs", {24'h0, sel_a, sel_b, sel_c, sel_en, busy, timeout, 2'b00}, 32'd0);
    check("reset_grant", {24'h0, grant}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_no_req", {22'h0, sel_en, busy, grant}, 32'd0);
    end

    // Single requester 0: one GRANT cycle, GAP, then IDLE.
    do_reset();
    push(3'd0, 1, 1'b0);
    req = 8'h01;
    tick();
    check("t2_grant", {24'h0, grant}, 32'h01);
    check("t2_idx", {29'h0, sel_a, sel_b, sel_c}, 32'd0);
    req = 8'h00;
    tick();
    check("t2_gap_grant", {24'h0, grant}, 32'h00);
    check("t2_gap_busy", {31'h0, busy}, 32'd1);
    tick();
    check("t2_idle_busy", {31'h0, busy}, 32'd0);

    // All requesting; each owner drops after 2 GRANT cycles and reasserts.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      push(3'(k % 8), 2, 1'b0);
      tick();
      tick();
      req[k % 8] = 1'b0;
      tick();
      if (k < 8) req[k % 8] = 1'b1;
      else       req = 8'h00;
    end
    tick();
    tick();

    // Two persistent requesters alternate via the hold limit.
    do_reset();
    push(3'd2, 16, 1'b1);
    push(3'd5, 16, 1'b1);
    push(3'd2, 16, 1'b1);
    req = 8'h24;
    repeat (51) tick();
    req = 8'h00;
    repeat (3) tick();

    // Release on the limit cycle counts as a voluntary release.
    do_reset();
    push(3'd2, 16, 1'b0);
    req = 8'h04;
    repeat (16) tick();
    req = 8'h00;
    repeat (3) tick();

    // Lone requester forced off is granted again after the gap.
    do_reset();
    push(3'd2, 16, 1'b1);
    push(3'd2, 3, 1'b0);
    req = 8'h04;
    repeat (20) tick();
    req = 8'h00;
    repeat (3) tick();

    // Reset during owner 3's GRANT, then ptr=0 gives 3 priority over 7.
    do_reset();
    push(3'd3, 2, 1'b0);
    req = 8'h08;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_reset_outputs", {24'h0, sel_a, sel_b, sel_c, sel_en, busy, timeout, 2'b00}, 32'd0);
    check("t5_reset_grant", {24'h0, grant}, 32'd0);
    reset = 1'b0;
    push(3'd3, 1, 1'b0);
    req = 8'h88;
    tick();
    check("t5_regrant", {24'h0, grant}, 32'h08);
    check("t5_regrant_idx", {29'h0, sel_a, sel_b, sel_c}, 32'd3);
    req = 8'h00;
    repeat (4) tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
